// File: rtl/aes128_enc_iter.sv
// aes128_enc_iter: iterative AES-128 encryptor, UNROLL rounds per clock, ECB/CBC with on-the-fly key schedule
module aes128_enc_iter #(
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  input  logic         cbc_en,
  input  logic         iv_load,
  input  logic [127:0] iv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext,
  output logic         busy
);
  localparam int N_CYC = 10 / UNROLL;
  if (N_CYC * UNROLL != 10) begin : g_bad_unroll
    $error("aes128_enc_iter: UNROLL must be 1, 2, 5 or 10");
  end
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t       st;
  logic [127:0] state_reg, key_reg, chain;
  logic [7:0]   rcon;
  logic [3:0]   rnd;
  logic         cbc_r;
  logic         take;
  logic [127:0] s_c [UNROLL+1];
  logic [127:0] k_c [UNROLL+1];
  logic [7:0]   r_c [UNROLL+1];
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction
  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
  // SubBytes + ShiftRows, then MixColumns unless this is the final round
  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic last);
    logic [127:0] sr, o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
    for (int c = 0; c < 4; c++)
      o[127-32*c -: 32] = last ? sr[127-32*c -: 32] : mix_col(sr[127-32*c -: 32]);
    return o;
  endfunction
  assign take     = (st == IDLE) || (st == DONE && out_ready);
  assign in_ready = rst_n && take;
  assign busy     = (st == BUSY);
  // unrolled chain of rounds with the key schedule running alongside
  always_comb begin
    s_c[0] = state_reg;
    k_c[0] = key_reg;
    r_c[0] = rcon;
    for (int j = 0; j < UNROLL; j++) begin
      k_c[j+1] = next_key(k_c[j], r_c[j]);
      r_c[j+1] = xt(r_c[j]);
      s_c[j+1] = enc_round(s_c[j], int'(rnd) + j == 9) ^ k_c[j+1];
    end
  end
  // control FSM, datapath registers, chaining register and output holding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      state_reg  <= '0;
      key_reg    <= '0;
      chain      <= '0;
      rcon       <= '0;
      rnd        <= '0;
      cbc_r      <= 1'b0;
      out_valid  <= 1'b0;
      ciphertext <= '0;
    end else begin
      if (take && iv_load) chain <= iv;
      if (take && in_valid) begin
        state_reg <= plaintext ^ (cbc_en ? (iv_load ? iv : chain) : 128'h0) ^ key;
        key_reg   <= key;
        rcon      <= 8'h01;
        rnd       <= '0;
        cbc_r     <= cbc_en;
        out_valid <= 1'b0;
        st        <= BUSY;
      end else if (st == DONE && out_ready) begin
        out_valid <= 1'b0;
        st        <= IDLE;
      end else if (st == BUSY) begin
        state_reg <= s_c[UNROLL];
        key_reg   <= k_c[UNROLL];
        rcon      <= r_c[UNROLL];
        rnd       <= rnd + 4'(UNROLL);
        if (rnd + 4'(UNROLL) == 4'd10) begin
          st         <= DONE;
          out_valid  <= 1'b1;
          ciphertext <= s_c[UNROLL];
          if (cbc_r) chain <= s_c[UNROLL];
        end
      end
    end
  end
endmodule

// File: tb/tb_aes128_enc_iter.sv
// tb_aes128_enc_iter: directed known-answer bench with scoreboard for every UNROLL variant
module tb_aes128_enc_iter;
  localparam int UL [4] = '{1, 2, 5, 10};
  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SP1 = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] SP2 = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] SP3 = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
  localparam logic [127:0] SP4 = 128'hf69f2445df4f9b17ad2b417be66c3710;
  localparam logic [127:0] E1  = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
  localparam logic [127:0] E2  = 128'hf5d3d58503b9699de785895a96fdbaaf;
  localparam logic [127:0] CB1 = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CB2 = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] CB3 = 128'h73bed6b8e3c1743b7116e69e22229516;
  localparam logic [127:0] CB4 = 128'h3ff1caa1681fac09120eca307586e1a7;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cbc_en = 1'b0, iv_load = 1'b0, out_ready = 1'b1;
  logic [127:0] plaintext = '0, key = '0, iv = '0;
  logic ir [4], ov [4], bz [4];
  logic [127:0] ctv [4];
  logic [127:0] exp_q [$];
  int checks = 0, errors = 0;
  int lat [4];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    aes128_enc_iter #(.UNROLL(UL[g])) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[g]),
      .plaintext(plaintext), .key(key), .cbc_en(cbc_en), .iv_load(iv_load), .iv(iv),
      .out_valid(ov[g]), .out_ready(out_ready), .ciphertext(ctv[g]), .busy(bz[g]));
  end
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [127:0] pt, input logic [127:0] k, input logic cbc,
                      input logic ivl, input logic [127:0] ivv, input logic [127:0] exp);
    int n = 0;
    plaintext = pt; key = k; cbc_en = cbc; iv_load = ivl; iv = ivv; in_valid = 1'b1;
    exp_q.push_back(exp);
    @(negedge clk);
    while (!ir[0] && n < 40) begin @(negedge clk); n++; end
    chk("accept_ready", 128'(ir[0]), 128'd1);
    @(posedge clk);
    #1 in_valid = 1'b0; iv_load = 1'b0;
  endtask
  task automatic wait_out(input string tag, input int exp_lat);
    int n = 0;
    logic [127:0] e;
    while (!ov[0] && n < 40) begin @(posedge clk); #1; n++; end
    chk({tag, "_lat"}, 128'(n), 128'(exp_lat));
    e = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
    chk({tag, "_ct"}, ctv[0], e);
  endtask
  initial begin
    #2;
    chk("rst_in_ready", 128'(ir[0]), 128'd0);
    chk("rst_out_valid", 128'(ov[0]), 128'd0);
    chk("rst_busy", 128'(bz[0]), 128'd0);
    chk("rst_ct", ctv[0], 128'd0);
    #10 rst_n = 1'b1;
    #1 chk("rel_in_ready", 128'(ir[0]), 128'd1);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(SP1, K2, 1'b0, 1'b0, '0, E1);
    lat = '{0, 0, 0, 0};
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (ov[i] && lat[i] == 0) lat[i] = e;
    end
    for (int i = 0; i < 4; i++) begin
      logic [127:0] ex;
      ex = E1;
      if (i == 0) ex = exp_q.pop_front();
      chk($sformatf("ecb_u%0d_lat", UL[i]), 128'(lat[i]), 128'(10 / UL[i]));
      chk($sformatf("ecb_u%0d_ct", UL[i]), ctv[i], ex);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(P1, K1, 1'b0, 1'b0, '0, C1);
    wait_out("fips", 10);
    send(SP1, K2, 1'b1, 1'b1, IV, CB1);
    wait_out("cbc1", 10);
    chk("b2b_ready", 128'(ir[0]), 128'd1);
    send(SP2, K2, 1'b1, 1'b0, '0, CB2);
    chk("b2b_busy", 128'(bz[0]), 128'd1);
    wait_out("cbc2", 10);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(P1, K1, 1'b0, 1'b0, '0, C1);
    wait_out("bp", 10);
    for (int c = 0; c < 7; c++) begin
      plaintext = {$urandom, $urandom, $urandom, $urandom};
      iv = {$urandom, $urandom, $urandom, $urandom};
      iv_load = c[0];
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_valid", 128'(ov[0]), 128'd1);
      chk("bp_ct", ctv[0], C1);
      chk("bp_in_ready", 128'(ir[0]), 128'd0);
    end
    in_valid = 1'b0; iv_load = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", 128'(ov[0]), 128'd0);
    send(SP3, K2, 1'b1, 1'b0, '0, CB3);
    wait_out("iso_cbc3", 10);
    send(SP2, K2, 1'b0, 1'b0, '0, E2);
    wait_out("iso_ecb", 10);
    send(SP4, K2, 1'b1, 1'b0, '0, CB4);
    wait_out("iso_cbc4", 10);
    @(posedge clk); #1;
    send(P1, K1, 1'b0, 1'b0, '0, C1);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 128'(bz[0]), 128'd1);
    chk("mid_ct_held", ctv[0], CB4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(ov[0]), 128'd0);
    chk("mid_rst_busy", 128'(bz[0]), 128'd0);
    chk("mid_rst_ct", ctv[0], 128'd0);
    chk("mid_rst_ready", 128'(ir[0]), 128'd0);
    void'(exp_q.pop_back());
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(P1, K1, 1'b0, 1'b0, '0, C1);
    wait_out("post_rst", 10);
    chk("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
